// File: rtl/axi_rd_burst_gen_pkg.sv
// Shared constants, state encoding and a width helper for the read burst generator.
package axi_rd_gen_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         AXI_4K         = 4096;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_gen_state_t;

    // Ceiling log2, used to derive arsize from the bus byte width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_rd_burst_gen_if.sv
// AXI4 read-only bus: AR and R channels with master/slave views.
interface axi_bus_rd_t #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_rd_burst_gen_len.sv
// Combinational burst length: smallest of remaining beats, the burst cap and
// the beats left before the next 4 KB page boundary.
module burst_len_calc
    import axi_rd_gen_pkg::*;
#(
    parameter int LEN_WIDTH     = 32,
    parameter int MAX_BURST_LEN = 64,
    parameter int BPB_LOG2      = 3
) (
    input  logic [11:0]          page_off,
    input  logic [LEN_WIDTH-1:0] rem,
    output logic [8:0]           blen
);
    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [12:0]   page_beats;
    logic [CW-1:0] cap;
    logic [CW-1:0] rem_x;

    // Clamp against page room first, then against what is left to issue.
    always_comb begin
        page_beats = (13'(AXI_4K) - {1'b0, page_off}) >> BPB_LOG2;
        cap        = (CW'(page_beats) < CW'(MAX_BURST_LEN)) ? CW'(page_beats) : CW'(MAX_BURST_LEN);
        rem_x      = CW'(rem);
        blen       = 9'((rem_x < cap) ? rem_x : cap);
    end
endmodule

// File: rtl/axi_rd_burst_gen.sv
// Splits one linear read command into INCR bursts and streams the read data out.
module axi_rd_burst_gen
    import axi_rd_gen_pkg::*;
#(
    parameter int MAX_BURST_LEN   = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LEN_WIDTH       = 32,
    parameter int AXI_ID          = 0,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int ID_W            = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_beats,
    axi_bus_rd_t.master          m_axi,
    output logic [DATA_W-1:0]    dout_data,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int BPB      = DATA_W / 8;
    localparam int BPB_LOG2 = clog2(BPB);
    localparam int OUT_W    = clog2(MAX_OUTSTANDING) + 1;

    rd_gen_state_t        state;
    logic                 cmd_ready_q;
    logic                 arvalid_q;
    logic                 done_q;
    logic                 err_q;
    logic [ADDR_W-1:0]    araddr_q;
    logic [7:0]           arlen_q;
    logic [8:0]           blen_q;
    logic [LEN_WIDTH-1:0] ar_rem;
    logic [LEN_WIDTH-1:0] r_rem;
    logic [OUT_W-1:0]     outstanding;

    logic                 accept;
    logic                 ar_hs;
    logic                 ar_free;
    logic                 r_hs;
    logic                 out_dec;
    logic                 out_room;
    logic                 ar_load;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [LEN_WIDTH-1:0] ar_rem_nxt;
    logic [LEN_WIDTH-1:0] r_rem_nxt;
    logic [OUT_W-1:0]     out_nxt;
    logic [11:0]          calc_off;
    logic [LEN_WIDTH-1:0] calc_rem;
    logic [8:0]           blen_nxt;

    // Next-state arithmetic; the length calculator sees the command in IDLE
    // and the post-handshake address/remainder while issuing, so ARs can go
    // out back to back.
    always_comb begin
        accept     = cmd_valid && cmd_ready_q;
        ar_hs      = arvalid_q && m_axi.arready;
        ar_free    = !arvalid_q || m_axi.arready;
        r_hs       = m_axi.rvalid && dout_ready;
        out_dec    = r_hs && m_axi.rlast && (outstanding != '0);
        addr_nxt   = ar_hs ? (araddr_q + (ADDR_W'(blen_q) << BPB_LOG2)) : araddr_q;
        ar_rem_nxt = ar_hs ? (ar_rem - LEN_WIDTH'(blen_q)) : ar_rem;
        r_rem_nxt  = (r_hs && (r_rem != '0)) ? (r_rem - LEN_WIDTH'(1)) : r_rem;
        out_nxt    = outstanding + OUT_W'(ar_hs) - OUT_W'(out_dec);
        out_room   = out_nxt < OUT_W'(MAX_OUTSTANDING);
        calc_off   = (state == IDLE) ? cmd_addr[11:0] : addr_nxt[11:0];
        calc_rem   = (state == IDLE) ? cmd_beats : ar_rem_nxt;
        ar_load    = (state == IDLE) ? accept : ((state == ISSUE) && ar_free);
    end

    burst_len_calc #(
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BPB_LOG2      (BPB_LOG2)
    ) u_len (
        .page_off (calc_off),
        .rem      (calc_rem),
        .blen     (blen_nxt)
    );

    // AR payload registers; only reloaded when no stalled request is pending.
    always_ff @(posedge clk) begin
        if (ar_load) begin
            araddr_q <= (state == IDLE) ? cmd_addr : addr_nxt;
            arlen_q  <= 8'(blen_nxt - 9'd1);
            blen_q   <= blen_nxt;
        end
    end

    // Control FSM: command accept, AR issue under the outstanding cap, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ar_rem      <= '0;
            r_rem       <= '0;
            outstanding <= '0;
        end else begin
            done_q      <= 1'b0;
            r_rem       <= r_rem_nxt;
            outstanding <= out_nxt;
            if (r_hs && ((m_axi.rresp != 2'b00) || (r_rem == '0))) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        ar_rem      <= cmd_beats;
                        r_rem       <= cmd_beats;
                        err_q       <= 1'b0;
                        if (cmd_beats == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            arvalid_q <= out_room;
                        end
                    end
                end
                ISSUE: begin
                    ar_rem <= ar_rem_nxt;
                    if (ar_free) begin
                        if (ar_rem_nxt == '0) begin
                            arvalid_q <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            arvalid_q <= out_room;
                        end
                    end
                end
                DRAIN: begin
                    if ((r_rem_nxt == '0) && (out_nxt == '0)) begin
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(BPB_LOG2);
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arid    = ID_W'(AXI_ID);
    assign m_axi.rready  = dout_ready;

    assign dout_valid = m_axi.rvalid;
    assign dout_data  = m_axi.rdata;
    assign dout_last  = m_axi.rvalid && (r_rem == LEN_WIDTH'(1));
    assign cmd_ready  = cmd_ready_q;
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Scoreboard bench: a memory-backed AXI slave, an arithmetic burst-split model
// and a negedge monitor comparing every AR and output beat.
module tb_axi_rd_burst_gen;
    localparam int BPB = 64;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_addr = '0;
    logic [31:0]  cmd_beats = '0;
    logic [511:0] dout_data;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         done;
    logic         err;

    axi_bus_rd_t #(.ADDR_W(32), .DATA_W(512), .ID_W(4)) bus ();

    axi_rd_burst_gen #(
        .MAX_BURST_LEN   (64),
        .MAX_OUTSTANDING (4),
        .LEN_WIDTH       (32),
        .AXI_ID          (5),
        .ADDR_W          (32),
        .DATA_W          (512),
        .ID_W            (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_beats  (cmd_beats),
        .m_axi      (bus),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    burst_t ar_exp[$];
    beat_t  d_exp[$];
    burst_t sl_q[$];

    bit ar_rand = 0, ar_hold = 0, r_rand = 0, dr_rand = 0, dr_hold = 0;
    int r_budget = -1;
    int err_beat = -1;
    int sl_beat  = 0;
    int sl_idx   = 0;
    int ar_count = 0;

    function automatic logic [511:0] mem_word(input logic [31:0] a);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_data(input string name, input logic [511:0] act, input logic [511:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Reference: split a linear read into INCR bursts by plain arithmetic.
    task automatic build_expect(input logic [31:0] a0, input int n);
        logic [31:0] a;
        int rem, page, b;
        a = a0;
        rem = n;
        while (rem > 0) begin
            page = (4096 - int'(a % 4096)) / BPB;
            b = rem;
            if (b > 64) b = 64;
            if (b > page) b = page;
            ar_exp.push_back('{addr: a, len: b});
            a = a + 32'(b * BPB);
            rem = rem - b;
        end
        for (int i = 0; i < n; i++)
            d_exp.push_back('{data: mem_word(a0 + 32'(i * BPB)), last: (i == n - 1)});
    endtask

    // AXI slave with a memory image; keeps rvalid up until taken.
    initial begin : slave
        logic ar_take, r_take, rv_keep, rst_s;
        logic [31:0] a_s;
        logic [7:0]  l_s;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        dout_ready  = 1'b0;
        forever begin
            @(negedge clk);
            rst_s   = rst;
            ar_take = bus.arvalid && bus.arready;
            r_take  = bus.rvalid && bus.rready;
            rv_keep = bus.rvalid && !bus.rready;
            a_s     = bus.araddr;
            l_s     = bus.arlen;
            @(posedge clk);
            #1;
            if (rst_s) begin
                sl_q.delete();
                sl_idx = 0;
                bus.rvalid = 1'b0;
            end else begin
                if (r_take && sl_q.size() > 0) begin
                    sl_idx++;
                    sl_beat++;
                    if (r_budget > 0) r_budget--;
                    if (sl_idx == sl_q[0].len) begin
                        void'(sl_q.pop_front());
                        sl_idx = 0;
                    end
                end
                if (ar_take) sl_q.push_back('{addr: a_s, len: int'(l_s) + 1});
                if (!rv_keep)
                    bus.rvalid = (sl_q.size() > 0) && (r_budget != 0) && (!r_rand || $urandom_range(0, 3) != 0);
            end
            if (sl_q.size() > 0) begin
                bus.rdata = mem_word(sl_q[0].addr + 32'(sl_idx * BPB));
                bus.rlast = (sl_idx == sl_q[0].len - 1);
                bus.rresp = (sl_beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                bus.rlast = 1'b0;
                bus.rresp = 2'b00;
            end
            bus.arready = ar_hold ? 1'b0 : (ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            dout_ready  = dr_hold ? 1'b0 : (dr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops expectations whenever the DUT presents an AR or output beat.
    initial begin : monitor
        bit prev_stall = 0, done_due = 0, next_due;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        int model_out = 0;
        burst_t eb;
        beat_t  ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                done_due   = 0;
                model_out  = 0;
                continue;
            end
            if (done_due || done) check("done_timing", 64'(done), 64'(done_due));
            next_due = cmd_valid && cmd_ready && (cmd_beats == 0);
            if (prev_stall) begin
                check("ar_hold_valid", 64'(bus.arvalid), 64'd1);
                check("ar_hold_addr", 64'(bus.araddr), 64'(prev_addr));
                check("ar_hold_len", 64'(bus.arlen), 64'(prev_len));
            end
            if (bus.arvalid && bus.arready) begin
                if (ar_exp.size() == 0) fail_now("ar_unexpected");
                else begin
                    eb = ar_exp.pop_front();
                    check("ar_addr", 64'(bus.araddr), 64'(eb.addr));
                    check("ar_len", 64'(bus.arlen), 64'(eb.len - 1));
                    check("ar_size", 64'(bus.arsize), 64'd6);
                    check("ar_burst", 64'(bus.arburst), 64'd1);
                    check("ar_id", 64'(bus.arid), 64'd5);
                end
                check("ar_outstanding_cap", 64'(model_out < 4), 64'd1);
                model_out++;
                ar_count++;
            end
            prev_stall = bus.arvalid && !bus.arready;
            prev_addr  = bus.araddr;
            prev_len   = bus.arlen;
            if (bus.rvalid && bus.rready && bus.rlast) model_out--;
            if (dout_valid && dout_ready) begin
                if (d_exp.size() == 0) fail_now("dout_unexpected");
                else begin
                    ed = d_exp.pop_front();
                    check_data("dout_data", dout_data, ed.data);
                    check("dout_last", 64'(dout_last), 64'(ed.last));
                    if (ed.last) next_due = 1;
                end
            end
            done_due = next_due;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_valid = 1'b0;
        ar_exp.delete();
        d_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] a, input int n);
        int t;
        @(negedge clk);
        sl_beat = 0;
        build_expect(a, n);
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_beats = 32'(n);
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 200);
        if (!cmd_ready) fail_now("cmd_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("err_clear_on_accept", 64'(err), 64'd0);
        if (n > 0) check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            fail_now("done_wait");
            do_reset();
        end else begin
            check("busy_at_done", 64'(busy), 64'd0);
            check("cmd_ready_at_done", 64'(cmd_ready), 64'd0);
            check("ar_queue_empty", 64'(ar_exp.size()), 64'd0);
            check("beat_queue_empty", 64'(d_exp.size()), 64'd0);
        end
    endtask

    task automatic run_cmd(input logic [31:0] a, input int n);
        start_cmd(a, n);
        wait_done();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, base, held;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        run_cmd(32'h0000_1000, 150);
        run_cmd(32'h0000_1F80, 10);

        // Outstanding cap: no read data, so AR issue must stop at four.
        r_budget = 0;
        base = ar_count;
        start_cmd(32'h0000_0000, 512);
        repeat (30) @(negedge clk);
        check("cap_ar_count", 64'(ar_count - base), 64'd4);
        check("cap_arvalid_low", 64'(bus.arvalid), 64'd0);
        r_budget = 64;
        t = 0;
        while (r_budget != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (r_budget != 0) fail_now("cap_release");
        repeat (10) @(negedge clk);
        check("cap_fifth_ar", 64'(ar_count - base), 64'd5);
        r_budget = -1;
        wait_done();

        // Output back-pressure mid-burst.
        start_cmd(32'h0000_2040, 200);
        t = 0;
        while (d_exp.size() > 150 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        dr_hold = 1;
        @(posedge clk);
        @(negedge clk);
        held = d_exp.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_rready", 64'(bus.rready), 64'd0);
        end
        check("stall_no_beat_lost", 64'(d_exp.size()), 64'(held));
        dr_hold = 0;
        wait_done();

        // Zero-length command issues no AR.
        base = ar_count;
        run_cmd(32'h0000_3000, 0);
        check("zero_no_ar", 64'(ar_count - base), 64'd0);

        // Error response on the third beat is sticky until the next accept.
        err_beat = 2;
        run_cmd(32'h0000_0FC0, 8);
        check("err_set", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        err_beat = -1;
        run_cmd(32'h0000_4000, 3);
        check("err_stays_clear", 64'(err), 64'd0);

        // Reset while an AR is stalled.
        ar_hold = 1;
        start_cmd(32'h0000_5000, 100);
        repeat (5) @(negedge clk);
        check("pre_rst_arvalid", 64'(bus.arvalid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ar_exp.delete();
        d_exp.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ar_hold = 0;
        @(negedge clk);
        check("abort_arvalid", 64'(bus.arvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("abort_cmd_ready_high", 64'(cmd_ready), 64'd1);

        // Randomized commands under random handshakes.
        for (int it = 0; it < 10; it++) begin
            ar_rand = 1'($urandom_range(0, 1));
            r_rand  = 1'($urandom_range(0, 1));
            dr_rand = 1'($urandom_range(0, 1));
            run_cmd(32'($urandom_range(0, 1023)) << 6, int'($urandom_range(0, 300)));
        end
        ar_rand = 0;
        r_rand  = 0;
        dr_rand = 0;
        repeat (5) @(negedge clk);
        check("final_ar_queue", 64'(ar_exp.size()), 64'd0);
        check("final_beat_queue", 64'(d_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_rd_burst_gen.md
# axi_rd_burst_gen

Read-side AXI4 burst generator. It accepts one linear read command (start address, beat count), splits it into INCR bursts that respect the maximum burst length, 4 KB boundaries and an outstanding-burst cap, and returns the read data as a valid/ready stream. It sits directly upstream of the AR/R register slice `axi_rd_register`: its `m_axi` port drives that slice's slave side.

## Interface
- `MAX_BURST_LEN`, default 64: maximum beats per burst (1..256, power of 2).
- `MAX_OUTSTANDING`, default 8: maximum issued-but-incomplete bursts (power of 2).
- `LEN_WIDTH`, default 32: width of the command beat count.
- `AXI_ID`, default 0: constant `arid` value.
- Data width and address width come from `axi_bus_rd_t`. Bytes per beat `BPB = $bits(rdata)/8`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_addr` in `$bits(araddr)`: start byte address; must be BPB-aligned.
- `cmd_beats` in LEN_WIDTH: total beats; 0 is legal.
- `m_axi` is an `axi_bus_rd_t.master` interface (AR and R channels).
- `dout_data` out `$bits(rdata)`: read data.
- `dout_last` out 1: final beat of the command.
- `dout_valid` out 1 / `dout_ready` in 1: output handshake.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when the command completes.
- `err` out 1: sticky; set if any beat has `rresp != 0`; cleared on command accept.

## Operation
- State machine has three states:
  - IDLE: `cmd_ready=1`. On accept, latch the address, `ar_rem = cmd_beats` and `r_rem = cmd_beats`, and clear `err`. If `cmd_beats==0`, pulse `done` next cycle and stay in IDLE; otherwise go to ISSUE.
  - ISSUE: burst length is `blen = min(ar_rem, MAX_BURST_LEN, (4096 - addr[11:0]) / BPB)`.
    - `arvalid` is asserted when `outstanding < MAX_OUTSTANDING`.
    - `arlen = blen-1`, `arsize = log2(BPB)`, `arburst = 2'b01`, `arid = AXI_ID`.
    - On AR handshake: `addr += blen*BPB`, `ar_rem -= blen`, `outstanding++`. When `ar_rem` reaches 0, go to DRAIN.
  - DRAIN: when `r_rem==0` and `outstanding==0`, pulse `done` and go to IDLE.
- AR fields are registered. While `arvalid && !arready`, all AR fields stay stable and `arvalid` is not withdrawn.
- R path is a combinational pass-through:
  - `rready = dout_ready`, `dout_valid = rvalid`, `dout_data = rdata`.
  - `dout_last = (r_rem==1)` on a valid beat. `rlast` is not forwarded.
- On each R handshake, `r_rem--`. If that beat also has `rlast`, `outstanding--`.
- A simultaneous AR handshake and R-last handshake leaves `outstanding` unchanged.
- `busy` = state != IDLE.

## Timing
- Reset values: `cmd_ready=0` during `rst` and 1 in the first cycle after; `arvalid=0`, `done=0`, `busy=0`, `err=0`. Counters are 0 and the state is IDLE.
- The first `arvalid` rises 1 cycle after command accept. Back-to-back ARs are allowed every cycle while the outstanding cap permits.
- `done` is asserted the cycle after the last R handshake (or the last-beat cycle in which `outstanding` drops to 0).
- A new command is accepted the cycle after `done`, at the earliest.
- Reset asserted mid-command aborts immediately: counters clear and `arvalid` drops on the next edge. Stale R beats after reset are a system-level concern; the block does not filter them.
- An R beat arriving while `r_rem==0` is still accepted and sets `err`.

## Structure
- Package `axi_rd_gen_pkg` holds:
  - `AXI_BURST_INCR = 2'b01`;
  - `AXI_4K = 4096`;
  - state enum `rd_gen_state_t {IDLE, ISSUE, DRAIN}`;
  - a function `clog2` helper for `arsize`.
- Sub-module `burst_len_calc` is purely combinational. It computes `blen` from address, `ar_rem` and `MAX_BURST_LEN`, and is unit-testable on its own.

## Test plan
- Command addr 0x1000, 150 beats, arready=1, rvalid always → three ARs:
  - 0x1000 with arlen 63;
  - 0x2000 with arlen 63;
  - 0x3000 with arlen 21.
  - 150 beats out, `dout_last` only on beat 150, `done` one cycle later.
- 4 KB crossing: addr 0x1F80, 10 beats (BPB=64) → two ARs: 0x1F80 with arlen 1, then 0x2000 with arlen 7.
- MAX_OUTSTANDING=4, 512 beats, rvalid held low → exactly 4 AR handshakes, then `arvalid=0`. Releasing one full burst of R beats → the fifth AR issues.
- `dout_ready=0` for 20 cycles mid-burst → `rready=0`, no beat lost, order preserved, `r_rem` frozen.
- `cmd_beats=0` → no AR, `done` high exactly 1 cycle after accept. A second command with `rresp=2'b10` on beat 3 → `err=1` until the next accept.
- `rst` pulsed during ISSUE with arvalid stalled → next cycle `arvalid=0`, `busy=0`, then `cmd_ready=1`.
